// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I-subset core.
// Steps FETCH/DECODE/EXEC/MEM/WB, drives datapath controls, traps.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        ALUD,
  output logic [2:0]  F,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] F7_Z    = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_wait;
  logic            r_trap;
  logic [1:0]      r_cause;
  logic [1:0]      w_cause;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_f3_base;
  logic            w_r_ok;
  logic            w_i_ok;
  logic            w_last;
  logic [2:0]      w_fmap;
  logic            w_unused_bits;

  assign w_op  = instr[6:0];
  assign w_f3  = instr[14:12];
  assign w_f7  = instr[31:25];
  assign w_unused_bits = ^{instr[24:15], instr[11:7]};

  // ADD/XOR/AND share funct3 legality; SRA needs the alternate funct7
  assign w_f3_base = (w_f3 == 3'b000) ||
                     (w_f3 == 3'b100) ||
                     (w_f3 == 3'b111);
  assign w_r_ok = (w_f3_base && w_f7 == F7_Z) ||
                  (w_f3 == 3'b101 && w_f7 == F7_ALT);
  assign w_i_ok = w_f3_base ||
                  (w_f3 == 3'b101 && w_f7 == F7_ALT);
  assign w_last = (r_wait == LAST);
  assign trap       = r_trap;
  assign trap_cause = r_cause;

  // funct3 to 2-bit ALU op remap used in the EXEC states
  always_comb begin
    w_fmap = 3'b000;
    unique case (w_f3)
      3'b100:  w_fmap = 3'b001;
      3'b111:  w_fmap = 3'b010;
      3'b101:  w_fmap = 3'b011;
      default: w_fmap = 3'b000;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RST;
    else     r_state <= w_next;
  end

  // memory wait counter, cleared whenever the state moves
  always_ff @(posedge clk) begin
    if (rst)
      r_wait <= '0;
    else if (w_next != r_state)
      r_wait <= '0;
    else if (mem_req && !mem_ready)
      r_wait <= r_wait + CW'(1);
  end

  // sticky trap flag and cause, captured on entry to TRAP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trap  <= 1'b0;
      r_cause <= 2'b00;
    end else if (r_state != S_TRAP && w_next == S_TRAP) begin
      r_trap  <= 1'b1;
      r_cause <= w_cause;
    end
  end

  // next-state and datapath control decode
  always_comb begin
    w_next     = r_state;
    w_cause    = 2'b00;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    ALUD       = 1'b0;
    F          = 3'b000;
    unique case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_last) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        unique case (1'b1)
          (w_op == OP_LW),
          (w_op == OP_SW):
            w_next = S_MEMADR;
          (w_op == OP_R && w_r_ok):
            w_next = S_EXECR;
          (w_op == OP_I && w_i_ok):
            w_next = S_EXECI;
          (w_op == OP_BR && w_f3 == 3'b000):
            w_next = S_BEQ;
          (w_op == OP_JAL):
            w_next = S_JAL;
          default: begin
            w_next  = S_TRAP;
            w_cause = 2'b01;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next = (w_op == OP_LW) ? S_MEMREAD
                                 : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end else if (w_last) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        result_src = 2'b01;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end else if (w_last) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        ALUD      = 1'b1;
        F         = w_fmap;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        ALUD      = 1'b1;
        F         = w_fmap;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        ALUD      = 1'b1;
        F         = 3'b001;
        pc_we     = zero;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_we     = 1'b1;
        w_next    = S_ALUWB;
      end
      S_TRAP: w_next = S_TRAP;
      default: w_next = S_RST;
    endcase
    // a reset cycle never commits architectural state
    if (rst) begin
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
      mem_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Directed instruction sequences; per-cycle expected controls queued.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, adr_src;
  logic        ir_we, pc_we, reg_we;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic        ALUD;
  logic [2:0]  F;
  logic        trap;
  logic [1:0]  trap_cause;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;
  exp_t q[$];

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D1B3;
  localparam logic [31:0] I_XORI = 32'h0050C193;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_SLL  = 32'h002091B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_JAL  = 32'h000000EF;

  multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_we(ir_we),
    .pc_we(pc_we), .reg_we(reg_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .ALUD(ALUD), .F(F),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [18:0] got;
  assign got = {mem_req, mem_we, adr_src, ir_we,
                pc_we, reg_we, alu_src_a, alu_src_b,
                result_src, ALUD, F, trap, trap_cause};

  function automatic logic [18:0] ev(
    input logic req, we, adr, irw, pcw, rgw,
    input logic [1:0] sa, sb, rs,
    input logic ad, input logic [2:0] f,
    input logic tr, input logic [1:0] tc);
    return {req, we, adr, irw, pcw, rgw,
            sa, sb, rs, ad, f, tr, tc};
  endfunction

  function automatic logic [18:0] e_exr(input logic [2:0] f);
    return ev(0,0,0,0,0,0, 2'b10,2'b00,2'b00, 1,f, 0,2'b00);
  endfunction
  function automatic logic [18:0] e_exi(input logic [2:0] f);
    return ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 1,f, 0,2'b00);
  endfunction
  function automatic logic [18:0] e_beq(input logic z);
    return ev(0,0,0,0,z,0, 2'b10,2'b00,2'b00, 1,3'b001, 0,2'b00);
  endfunction
  function automatic logic [18:0] e_trap(input logic [1:0] c);
    return ev(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,3'b000, 1,c);
  endfunction

  logic [18:0] E_RST, E_FW, E_FR, E_DEC, E_AWB;
  logic [18:0] E_MA, E_MR, E_MWB, E_MW, E_JAL;

  // drive one cycle of inputs and queue the expected controls
  task automatic cyc(input logic r, input logic [31:0] ins,
                     input logic z, input logic rdy,
                     input logic [18:0] ex, input string nm);
    @(posedge clk);
    #1;
    rst = r;
    instr = ins;
    zero = z;
    mem_ready = rdy;
    q.push_back('{name: nm, v: ex});
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits,
                       input string nm);
    for (int i = 0; i < waits; i++)
      cyc(0, ins, 0, 0, E_FW, {nm, "_fwait"});
    cyc(0, ins, 0, 1, E_FR, {nm, "_fetch"});
    cyc(0, ins, 0, 0, E_DEC, {nm, "_dec"});
  endtask

  // monitor: compare every queued expectation against the DUT
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s got=%05h exp=%05h",
                   e.name, got, e.v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    E_RST = '0;
    E_FW  = ev(1,0,0,0,0,0, 2'b00,2'b10,2'b10, 0,3'b0, 0,2'b00);
    E_FR  = ev(1,0,0,1,1,0, 2'b00,2'b10,2'b10, 0,3'b0, 0,2'b00);
    E_DEC = ev(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 0,3'b0, 0,2'b00);
    E_AWB = ev(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 0,3'b0, 0,2'b00);
    E_MA  = ev(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 0,3'b0, 0,2'b00);
    E_MR  = ev(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,3'b0, 0,2'b00);
    E_MWB = ev(0,0,0,0,0,1, 2'b00,2'b00,2'b01, 0,3'b0, 0,2'b00);
    E_MW  = ev(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,3'b0, 0,2'b00);
    E_JAL = ev(0,0,0,0,1,0, 2'b01,2'b10,2'b00, 0,3'b0, 0,2'b00);

    cyc(1, 0, 0, 0, E_RST, "rst0");
    cyc(1, 0, 0, 0, E_RST, "rst1");
    cyc(0, 0, 0, 0, E_RST, "rst_release");

    fetch(I_ADD, 0, "add");
    cyc(0, I_ADD, 0, 0, e_exr(3'b000), "add_exec");
    cyc(0, I_ADD, 0, 0, E_AWB, "add_wb");

    fetch(I_SRA, 0, "sra");
    cyc(0, I_SRA, 0, 0, e_exr(3'b011), "sra_exec");
    cyc(0, I_SRA, 0, 0, E_AWB, "sra_wb");

    fetch(I_XORI, 0, "xori");
    cyc(0, I_XORI, 0, 0, e_exi(3'b001), "xori_exec");
    cyc(0, I_XORI, 0, 0, E_AWB, "xori_wb");

    fetch(I_ADDI, 0, "addi");
    cyc(0, I_ADDI, 0, 0, e_exi(3'b000), "addi_exec");
    cyc(0, I_ADDI, 0, 0, E_AWB, "addi_wb");

    fetch(I_LW, 3, "lw");
    cyc(0, I_LW, 0, 0, E_MA, "lw_adr");
    for (int i = 0; i < 3; i++)
      cyc(0, I_LW, 0, 0, E_MR, "lw_rwait");
    cyc(0, I_LW, 0, 1, E_MR, "lw_read");
    cyc(0, I_LW, 0, 0, E_MWB, "lw_wb");

    fetch(I_SW, 0, "sw");
    cyc(0, I_SW, 0, 0, E_MA, "sw_adr");
    cyc(0, I_SW, 0, 1, E_MW, "sw_write");

    fetch(I_BEQ, 0, "beq1");
    cyc(0, I_BEQ, 1, 0, e_beq(1'b1), "beq_taken");
    fetch(I_BEQ, 0, "beq0");
    cyc(0, I_BEQ, 0, 0, e_beq(1'b0), "beq_not");

    fetch(I_JAL, 0, "jal");
    cyc(0, I_JAL, 0, 0, E_JAL, "jal_exec");
    cyc(0, I_JAL, 0, 0, E_AWB, "jal_wb");

    cyc(1, I_ADD, 0, 1, E_FW, "rst_mid_fetch");
    cyc(0, I_ADD, 0, 0, E_RST, "rst_mid_idle");

    fetch(I_SLL, 0, "sll");
    cyc(0, I_SLL, 0, 1, e_trap(2'b01), "sll_trap0");
    cyc(0, I_SLL, 0, 1, e_trap(2'b01), "sll_trap1");
    cyc(1, I_ADD, 0, 0, e_trap(2'b01), "sll_trap_rst");
    cyc(0, I_ADD, 0, 0, E_RST, "sll_rst_idle");

    for (int i = 0; i < 4; i++)
      cyc(0, I_ADD, 0, 0, E_FW, "tmo_fwait");
    cyc(0, I_ADD, 0, 1, e_trap(2'b10), "tmo_trap0");
    cyc(0, I_ADD, 0, 0, e_trap(2'b10), "tmo_trap1");
    cyc(1, I_ADD, 0, 0, e_trap(2'b10), "tmo_trap_rst");
    cyc(0, I_ADD, 0, 0, E_RST, "tmo_rst_idle");

    fetch(I_ADD, 3, "edge");
    cyc(0, I_ADD, 0, 0, e_exr(3'b000), "edge_exec");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
